// File: rtl/vga_timing_pkg.sv
// Shared timing defaults, helpers and the output flag bundle for the VGA timing generator.
package vga_timing_pkg;

  localparam int unsigned DEF_CLK_DIV    = 2;
  localparam int unsigned DEF_H_ACTIVE   = 640;
  localparam int unsigned DEF_H_FP       = 16;
  localparam int unsigned DEF_H_SYNC     = 96;
  localparam int unsigned DEF_H_BP       = 48;
  localparam int unsigned DEF_V_ACTIVE   = 480;
  localparam int unsigned DEF_V_FP       = 10;
  localparam int unsigned DEF_V_SYNC     = 2;
  localparam int unsigned DEF_V_BP       = 33;
  localparam int unsigned DEF_PIPE_DELAY = 0;
  localparam int unsigned DEF_CW         = 11;

  localparam int unsigned POL_ACTIVE_LOW  = 0;
  localparam int unsigned POL_ACTIVE_HIGH = 1;

  // One-bit outputs travelling together through the output pipeline.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic video_on;
    logic pix_stb;
    logic line_start;
    logic frame_start;
  } vga_flags_t;

  localparam int unsigned FLAGS_W = $bits(vga_flags_t);

  // Total period of a line or frame: active + front porch + sync + back porch.
  function automatic int unsigned timing_total(input int unsigned active, input int unsigned fp,
                                               input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth register chain with synchronous reset to a programmable vector; DEPTH=0 is a wire.
module vga_delay_line #(
  parameter int unsigned      WIDTH   = 1,
  parameter int unsigned      DEPTH   = 0,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  if (DEPTH == 0) begin : g_pass
    logic unused_ctrl;
    assign unused_ctrl = clk ^ reset;
    assign dout_o      = din_i;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage_q [DEPTH];

    // Shift the bundle one stage per clk; reset loads the idle vector everywhere.
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= RST_VAL;
      end else begin
        stage_q[0] <= din_i;
        for (int i = 1; i < int'(DEPTH); i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign dout_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Programmable VGA sync/coordinate generator with pixel-clock divider and output delay.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV    = DEF_CLK_DIV,
  parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
  parameter int unsigned H_FP       = DEF_H_FP,
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_BP       = DEF_H_BP,
  parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
  parameter int unsigned V_FP       = DEF_V_FP,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BP       = DEF_V_BP,
  parameter int unsigned HS_POL     = POL_ACTIVE_LOW,
  parameter int unsigned VS_POL     = POL_ACTIVE_LOW,
  parameter int unsigned PIPE_DELAY = DEF_PIPE_DELAY,
  parameter int unsigned CW         = DEF_CW
) (
  input  logic          clk,
  input  logic          reset,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          pix_stb,
  output logic          line_start,
  output logic          frame_start
);

  localparam int unsigned H_TOTAL  = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL  = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned HS_FIRST = H_ACTIVE + H_FP;
  localparam int unsigned HS_LAST  = H_ACTIVE + H_FP + H_SYNC - 1;
  localparam int unsigned VS_FIRST = V_ACTIVE + V_FP;
  localparam int unsigned VS_LAST  = V_ACTIVE + V_FP + V_SYNC - 1;
  localparam int unsigned DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned OUT_W    = FLAGS_W + 2 * CW;
  localparam longint unsigned CAP  = 64'(1) << CW;
  localparam logic HS_ACT          = 1'(HS_POL);
  localparam logic VS_ACT          = 1'(VS_POL);

  localparam vga_flags_t FLAGS_RST = vga_flags_t'{~HS_ACT, ~VS_ACT, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [OUT_W-1:0] OUT_RST = {FLAGS_RST, CW'(0), CW'(0)};

  if (CLK_DIV < 1 || H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 || PIPE_DELAY > 15 ||
      64'(H_TOTAL) > CAP || 64'(V_TOTAL) > CAP) begin : g_cfg_err
    $error("vga_timing_gen: illegal timing configuration");
  end

  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] h_q, h_d, v_q, v_d;
  logic          tick;
  vga_flags_t    flags_q, flags_d;
  logic [CW-1:0] x_q, y_q;
  logic [OUT_W-1:0] dly_out;

  // Divider and raster counters: pixel advances on tick, line advances at end of line.
  always_comb begin
    tick  = (div_q == DW'(CLK_DIV - 1));
    div_d = tick ? '0 : div_q + DW'(1);
    h_d   = h_q;
    v_d   = v_q;
    if (tick) begin
      if (h_q == CW'(H_TOTAL - 1)) begin
        h_d = '0;
        v_d = (v_q == CW'(V_TOTAL - 1)) ? '0 : v_q + CW'(1);
      end else begin
        h_d = h_q + CW'(1);
      end
    end
  end

  // Counter state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
    end
  end

  // Decode sync windows, active area and strobes from the current counters.
  always_comb begin
    flags_d             = FLAGS_RST;
    flags_d.hsync       = (h_q >= CW'(HS_FIRST) && h_q <= CW'(HS_LAST)) ? HS_ACT : ~HS_ACT;
    flags_d.vsync       = (v_q >= CW'(VS_FIRST) && v_q <= CW'(VS_LAST)) ? VS_ACT : ~VS_ACT;
    flags_d.video_on    = (h_q < CW'(H_ACTIVE)) && (v_q < CW'(V_ACTIVE));
    flags_d.pix_stb     = (div_q == '0);
    flags_d.line_start  = flags_d.pix_stb && (h_q == '0);
    flags_d.frame_start = flags_d.line_start && (v_q == '0);
  end

  // First output stage: always registered, regardless of PIPE_DELAY.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= FLAGS_RST;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      flags_q <= flags_d;
      x_q     <= h_q;
      y_q     <= v_q;
    end
  end

  vga_delay_line #(
    .WIDTH   (OUT_W),
    .DEPTH   (PIPE_DELAY),
    .RST_VAL (OUT_RST)
  ) u_delay (
    .clk    (clk),
    .reset  (reset),
    .din_i  ({flags_q, x_q, y_q}),
    .dout_o (dly_out)
  );

  assign {hsync, vsync, video_on, pix_stb, line_start, frame_start, pixel_x, pixel_y} = dly_out;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: reference-model scoreboard on four configurations plus directed corners.
module tb_vga_timing_gen;

  typedef struct packed {
    logic hs, vs, vid, stb, ls, fs;
    logic [15:0] x, y;
  } obs_t;

  typedef struct {
    int   k;
    obs_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_a, rst_b, rst_c;
  int   k_a = 0, k_b = 0, k_c = 0;
  bit   chk_en = 1'b0;
  int   n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  logic hs_def, vs_def, vid_def, stb_def, ls_def, fs_def;
  logic [10:0] x_def, y_def;
  logic hs_dly, vs_dly, vid_dly, stb_dly, ls_dly, fs_dly;
  logic [10:0] x_dly, y_dly;
  logic hs_sm, vs_sm, vid_sm, stb_sm, ls_sm, fs_sm;
  logic [10:0] x_sm, y_sm;
  logic hs_rn, vs_rn, vid_rn, stb_rn, ls_rn, fs_rn;
  logic [4:0] x_rn, y_rn;

  vga_timing_gen u_def (
    .clk(clk), .reset(rst_a), .hsync(hs_def), .vsync(vs_def), .video_on(vid_def),
    .pixel_x(x_def), .pixel_y(y_def), .pix_stb(stb_def), .line_start(ls_def), .frame_start(fs_def));

  vga_timing_gen #(.PIPE_DELAY(3)) u_dly (
    .clk(clk), .reset(rst_a), .hsync(hs_dly), .vsync(vs_dly), .video_on(vid_dly),
    .pixel_x(x_dly), .pixel_y(y_dly), .pix_stb(stb_dly), .line_start(ls_dly), .frame_start(fs_dly));

  vga_timing_gen #(.CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
                   .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1), .VS_POL(1)) u_small (
    .clk(clk), .reset(rst_b), .hsync(hs_sm), .vsync(vs_sm), .video_on(vid_sm),
    .pixel_x(x_sm), .pixel_y(y_sm), .pix_stb(stb_sm), .line_start(ls_sm), .frame_start(fs_sm));

  vga_timing_gen #(.CLK_DIV(3), .H_ACTIVE(5), .H_FP(1), .H_SYNC(2), .H_BP(1),
                   .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(2), .HS_POL(1), .VS_POL(0),
                   .PIPE_DELAY(2), .CW(5)) u_rnd (
    .clk(clk), .reset(rst_c), .hsync(hs_rn), .vsync(vs_rn), .video_on(vid_rn),
    .pixel_x(x_rn), .pixel_y(y_rn), .pix_stb(stb_rn), .line_start(ls_rn), .frame_start(fs_rn));

  obs_t o_def, o_dly, o_sm, o_rn;
  assign o_def = {hs_def, vs_def, vid_def, stb_def, ls_def, fs_def, 16'(x_def), 16'(y_def)};
  assign o_dly = {hs_dly, vs_dly, vid_dly, stb_dly, ls_dly, fs_dly, 16'(x_dly), 16'(y_dly)};
  assign o_sm  = {hs_sm, vs_sm, vid_sm, stb_sm, ls_sm, fs_sm, 16'(x_sm), 16'(y_sm)};
  assign o_rn  = {hs_rn, vs_rn, vid_rn, stb_rn, ls_rn, fs_rn, 16'(x_rn), 16'(y_rn)};

  // Expected outputs n clk after the first post-reset capture (n<0: still idle).
  function automatic obs_t ref_out(input int n, input int cd, input int ha, input int hf,
                                   input int hsw, input int hb, input int va, input int vf,
                                   input int vsw, input int vb, input logic hp, input logic vp);
    obs_t o;
    int p, x, y;
    o = '0;
    o.hs = ~hp;
    o.vs = ~vp;
    if (n < 0) return o;
    p = n / cd;
    x = p % (ha + hf + hsw + hb);
    y = (p / (ha + hf + hsw + hb)) % (va + vf + vsw + vb);
    o.x   = 16'(x);
    o.y   = 16'(y);
    o.hs  = (x >= ha + hf && x < ha + hf + hsw) ? hp : ~hp;
    o.vs  = (y >= va + vf && y < va + vf + vsw) ? vp : ~vp;
    o.vid = (x < ha) && (y < va);
    o.stb = (n % cd) == 0;
    o.ls  = o.stb && (x == 0);
    o.fs  = o.ls && (y == 0);
    return o;
  endfunction

  function automatic obs_t mk(input logic hs, input logic vs, input logic vid, input logic stb,
                              input logic ls, input logic fs, input int x, input int y);
    return {hs, vs, vid, stb, ls, fs, 16'(x), 16'(y)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Edges since each reset was last sampled high.
  always @(posedge clk) begin
    k_a <= rst_a ? 0 : k_a + 1;
    k_b <= rst_b ? 0 : k_b + 1;
    k_c <= rst_c ? 0 : k_c + 1;
  end

  // Cycle-by-cycle scoreboard of every instance against the arithmetic model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_def", o_def, ref_out(k_a - 1, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0));
      check("model_dly", o_dly, ref_out(k_a - 4, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0));
      check("model_small", o_sm, ref_out(k_b - 1, 1, 8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 1'b1));
      check("model_rnd", o_rn, ref_out(k_c - 3, 3, 5, 1, 2, 1, 3, 1, 1, 2, 1'b1, 1'b0));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[10];
    obs_t rst_def;
    int   g, hs_low, vid_cnt, x_first, x_last, period;
    int   vs_hi, vs_bad, hs_hi, hs_bad, stb_cnt, y_prev, y_wrap;
    int   hold;

    rst_def = mk(1, 1, 0, 0, 0, 0, 0, 0);
    vecs[0] = '{1,    mk(1, 1, 1, 1, 1, 1, 0, 0)};
    vecs[1] = '{2,    mk(1, 1, 1, 0, 0, 0, 0, 0)};
    vecs[2] = '{3,    mk(1, 1, 1, 1, 0, 0, 1, 0)};
    vecs[3] = '{1279, mk(1, 1, 1, 1, 0, 0, 639, 0)};
    vecs[4] = '{1281, mk(1, 1, 0, 1, 0, 0, 640, 0)};
    vecs[5] = '{1313, mk(0, 1, 0, 1, 0, 0, 656, 0)};
    vecs[6] = '{1504, mk(0, 1, 0, 0, 0, 0, 751, 0)};
    vecs[7] = '{1505, mk(1, 1, 0, 1, 0, 0, 752, 0)};
    vecs[8] = '{1600, mk(1, 1, 0, 0, 0, 0, 799, 0)};
    vecs[9] = '{1601, mk(1, 1, 1, 1, 1, 0, 0, 1)};

    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    repeat (4) @(negedge clk);
    check("reset_def", o_def, rst_def);
    check("reset_dly", o_dly, rst_def);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

    // Table of default-config snapshots at chosen clk offsets after release.
    for (int i = 0; i < 10; i++) begin
      g = 0;
      while (k_a < vecs[i].k && g < 4000) begin @(negedge clk); g++; end
      check($sformatf("vec_k%0d", vecs[i].k), o_def, vecs[i].exp);
    end

    // One full default line: sync window, active width, line period.
    g = 0;
    do begin @(negedge clk); g++; end while (!ls_def && g < 4000);
    check("line_found", 64'(ls_def), 64'(1));
    hs_low = 0; vid_cnt = 0; x_first = -1; x_last = -1; period = 0;
    for (int t = 0; t <= 1600; t++) begin
      if (t > 0 && ls_def && period == 0) period = t;
      if (t < 1600) begin
        if (!hs_def) begin
          hs_low++;
          if (x_first < 0) x_first = int'(x_def);
          x_last = int'(x_def);
        end
        if (vid_def) vid_cnt++;
      end
      @(negedge clk);
    end
    check("hs_low_clk", 64'(hs_low), 64'(192));
    check("hs_first_x", 64'(x_first), 64'(656));
    check("hs_last_x", 64'(x_last), 64'(751));
    check("vid_clk", 64'(vid_cnt), 64'(1280));
    check("line_period", 64'(period), 64'(1600));

    // Small active-high config over one frame.
    g = 0;
    while (!fs_sm && g < 200) begin @(negedge clk); g++; end
    check("small_fs_found", 64'(fs_sm), 64'(1));
    vs_hi = 0; vs_bad = 0; hs_hi = 0; hs_bad = 0; stb_cnt = 0; period = 0; y_prev = 0; y_wrap = -1;
    for (int t = 0; t <= 98; t++) begin
      if (t > 0 && fs_sm && period == 0) begin
        period = t;
        y_wrap = y_prev;
      end
      if (t < 98) begin
        if (vs_sm) begin vs_hi++; if (y_sm != 11'd5) vs_bad++; end
        if (stb_sm) stb_cnt++;
        if (t < 14 && hs_sm) begin hs_hi++; if (x_sm != 11'd10 && x_sm != 11'd11) hs_bad++; end
      end
      y_prev = int'(y_sm);
      @(negedge clk);
    end
    check("small_frame_period", 64'(period), 64'(98));
    check("small_y_wrap_from", 64'(y_wrap), 64'(6));
    check("small_vs_clk", 64'(vs_hi), 64'(14));
    check("small_vs_wrong_y", 64'(vs_bad), 64'(0));
    check("small_hs_clk", 64'(hs_hi), 64'(2));
    check("small_hs_wrong_x", 64'(hs_bad), 64'(0));
    check("small_stb_clk", 64'(stb_cnt), 64'(98));

    // Mid-line reset at x=300 on the default pair.
    g = 0;
    while (x_def != 11'd300 && g < 2000) begin @(negedge clk); g++; end
    check("x300_found", 64'(x_def), 64'(300));
    rst_a = 1'b1;
    @(negedge clk);
    check("midrst_def", o_def, rst_def);
    check("midrst_dly", o_dly, rst_def);
    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    @(negedge clk);
    check("restart_def", o_def, mk(1, 1, 1, 1, 1, 1, 0, 0));
    check("restart_dly_idle", o_dly, rst_def);
    repeat (2) @(negedge clk);
    check("restart_dly_idle3", o_dly, rst_def);
    @(negedge clk);
    check("restart_dly_fs", o_dly, mk(1, 1, 1, 1, 1, 1, 0, 0));

    // Random reset pulses on the divided, delayed instance.
    hold = 0;
    for (int t = 0; t < 2500; t++) begin
      @(negedge clk);
      if (hold > 0) begin
        hold--;
        if (hold == 0) rst_c = 1'b0;
      end else if ($urandom_range(0, 149) == 0) begin
        rst_c = 1'b1;
        hold  = int'($urandom_range(1, 4));
      end
    end
    rst_c = 1'b0;
    repeat (20) @(negedge clk);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
